qspi_fill_arbiter: RTL and testbench

- Shares one QSPI flash line reader (128-bit line fill, single-cycle `rd` strobe, single-cycle `done` pulse) between two line-fill requesters, e.g. the instruction cache and a data/literal-pool cache.
- Arbitrates between the two, issues line-aligned reads, and waits for completion.
- Returns a completion pulse to the owning requester, or to both requesters when they ask for the same line.
- Enforces a minimum idle gap between flash transactions so chip-enable deassert time is met.

---
 rtl/qspi_fill_arbiter_if.sv | 25 ++
 rtl/qspi_fill_arbiter.sv | 151 +++++++++++++++
 tb/tb_qspi_fill_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_fill_arbiter_if.sv
// Bundle of requester and flash-reader signals around qspi_fill_arbiter.
// master: the arbiter side. slave: requesters plus flash reader.
interface qspi_fill_arbiter_if;
    logic        req0;
    logic [23:0] addr0;
    logic        done0;
    logic        req1;
    logic [23:0] addr1;
    logic        done1;
    logic [23:0] fr_addr;
    logic        fr_rd;
    logic        fr_done;
    logic        busy;
    logic        owner;

    modport master (
        input  req0, addr0, req1, addr1, fr_done,
        output done0, done1, fr_addr, fr_rd, busy, owner
    );

    modport slave (
        output req0, addr0, req1, addr1, fr_done,
        input  done0, done1, fr_addr, fr_rd, busy, owner
    );
endinterface

// File: rtl/qspi_fill_arbiter.sv
// Two-requester arbiter in front of a single QSPI line reader.
// Grants one 16-byte line fill at a time, merges same-line requests,
// and holds a GAP_CYCLES idle gap after each completion.
// Optional macro QSPI_ARB_FIXED_PRIO_EN: requester 0 always wins ties
// (no round-robin pointer); undefined gives round-robin.
module qspi_fill_arbiter #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    qspi_fill_arbiter_if.master        bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    logic [1:0]  state_q,   state_d;
    logic        owner_q,   owner_d;
    logic [23:0] fr_addr_q, fr_addr_d;
    logic        merge_q,   merge_d;
    logic        fr_rd_q,   fr_rd_d;
    logic        done0_q,   done0_d;
    logic        done1_q,   done1_d;
    logic [3:0]  gap_q,     gap_d;

    logic        eff0, eff1, win, other_req;
    logic [23:0] addr_w, addr_o;

    // A request still high in its own done cycle is the finished one, not a
    // new one; masking it stops a duplicate fill when GAP_CYCLES is 0.
    assign eff0 = bus.req0 & ~done0_q;
    assign eff1 = bus.req1 & ~done1_q;

`ifdef QSPI_ARB_FIXED_PRIO_EN
    // Winner selection: requester 0 has absolute priority
    always_comb begin
        win = ~eff0;
    end
`else
    logic last_q, last_d;

    // Winner selection: on a tie the requester other than the last owner wins
    always_comb begin
        win = (eff0 & eff1) ? ~last_q : eff1;
    end

    // Round-robin pointer; resets to 1 so requester 0 wins the first tie
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // Pointer follows the owner of each completed transaction
    always_comb begin
        last_d = last_q;
        if (state_q == BUSY && bus.fr_done) begin
            last_d = owner_q;
        end
    end
`endif

    assign addr_w    = win ? bus.addr1 : bus.addr0;
    assign addr_o    = win ? bus.addr0 : bus.addr1;
    assign other_req = win ? eff0 : eff1;

    // Next-state logic for grant, issue, completion and inter-transaction gap
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        fr_addr_d = fr_addr_q;
        merge_d   = merge_q;
        gap_d     = gap_q;
        fr_rd_d   = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (eff0 | eff1) begin
                    owner_d   = win;
                    fr_addr_d = {addr_w[23:4], 4'h0};
                    merge_d   = other_req && (addr_o[23:4] == addr_w[23:4]);
                    fr_rd_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.fr_done) begin
                    done0_d = ~owner_q | merge_q;
                    done1_d = owner_q | merge_q;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            fr_addr_q <= '0;
            merge_q   <= 1'b0;
            fr_rd_q   <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            fr_addr_q <= fr_addr_d;
            merge_q   <= merge_d;
            fr_rd_q   <= fr_rd_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            gap_q     <= gap_d;
        end
    end

    assign bus.fr_rd   = fr_rd_q;
    assign bus.fr_addr = fr_addr_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_fill_arbiter.sv
// Directed self-checking bench for qspi_fill_arbiter.
// dut_a uses the default gap of 2 cycles, dut_b uses GAP_CYCLES = 0.
module tb_qspi_fill_arbiter;

    logic HCLK;
    logic HRESETn;
    int   n_cmp;
    int   n_err;

    qspi_fill_arbiter_if ifa ();
    qspi_fill_arbiter_if ifb ();

    qspi_fill_arbiter #(.GAP_CYCLES(2)) dut_a (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (ifa)
    );

    qspi_fill_arbiter #(.GAP_CYCLES(0)) dut_b (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (ifb)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.addr0 = '0; ifa.addr1 = '0; ifa.fr_done = 1'b0;
        ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.addr0 = '0; ifb.addr1 = '0; ifb.fr_done = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        clear_inputs();
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, ".busy"},    32'(ifa.busy),    32'h0);
        chk({tag, ".owner"},   32'(ifa.owner),   32'h0);
        chk({tag, ".fr_rd"},   32'(ifa.fr_rd),   32'h0);
        chk({tag, ".fr_addr"}, 32'(ifa.fr_addr), 32'h0);
        chk({tag, ".done0"},   32'(ifa.done0),   32'h0);
        chk({tag, ".done1"},   32'(ifa.done1),   32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        do_reset();
        chk_idle_a("rst");

        // Single request: grant, issue, done, two GAP cycles
        ifa.req0 = 1'b1; ifa.addr0 = 24'h012345;
        tick();
        chk("t1.rd",    32'(ifa.fr_rd),   32'h1);
        chk("t1.addr",  32'(ifa.fr_addr), 32'h012340);
        chk("t1.owner", 32'(ifa.owner),   32'h0);
        chk("t1.busy",  32'(ifa.busy),    32'h1);
        tick();
        chk("t1.rd_once", 32'(ifa.fr_rd), 32'h0);
        ifa.fr_done = 1'b1;
        tick();
        ifa.fr_done = 1'b0;
        chk("t1.done0", 32'(ifa.done0), 32'h1);
        chk("t1.done1", 32'(ifa.done1), 32'h0);
        chk("t1.busy_gap", 32'(ifa.busy), 32'h1);
        ifa.req0 = 1'b0;
        tick();
        chk("t1.done0_end", 32'(ifa.done0), 32'h0);
        chk("t1.busy_gap2", 32'(ifa.busy),  32'h1);
        tick();
        chk("t1.idle", 32'(ifa.busy), 32'h0);
        chk("t1.addr_hold", 32'(ifa.fr_addr), 32'h012340);

        // Both requesting: 0 first, then arbitration with 0 re-asserted
        do_reset();
        ifa.req0 = 1'b1; ifa.addr0 = 24'h000100;
        ifa.req1 = 1'b1; ifa.addr1 = 24'h000200;
        tick();
        chk("t2.owner_a", 32'(ifa.owner),   32'h0);
        chk("t2.addr_a",  32'(ifa.fr_addr), 32'h000100);
        chk("t2.rd_a",    32'(ifa.fr_rd),   32'h1);
        tick();
        ifa.fr_done = 1'b1;
        tick();
        ifa.fr_done = 1'b0;
        chk("t2.done0", 32'(ifa.done0), 32'h1);
        chk("t2.done1_nomerge", 32'(ifa.done1), 32'h0);
        ifa.req0 = 1'b0;
        tick();
        tick();
        chk("t2.idle", 32'(ifa.busy), 32'h0);
        ifa.req0 = 1'b1;
        tick();
        chk("t2.rd_b", 32'(ifa.fr_rd), 32'h1);
`ifdef QSPI_ARB_FIXED_PRIO_EN
        chk("t2.owner_b", 32'(ifa.owner),   32'h0);
        chk("t2.addr_b",  32'(ifa.fr_addr), 32'h000100);
`else
        chk("t2.owner_b", 32'(ifa.owner),   32'h1);
        chk("t2.addr_b",  32'(ifa.fr_addr), 32'h000200);
`endif
        tick();
        ifa.fr_done = 1'b1;
        tick();
        ifa.fr_done = 1'b0;
`ifdef QSPI_ARB_FIXED_PRIO_EN
        chk("t2.done_b0", 32'(ifa.done0), 32'h1);
        chk("t2.done_b1", 32'(ifa.done1), 32'h0);
`else
        chk("t2.done_b0", 32'(ifa.done0), 32'h0);
        chk("t2.done_b1", 32'(ifa.done1), 32'h1);
`endif

        // Same line from both: one read, both dones together
        do_reset();
        ifa.req0 = 1'b1; ifa.addr0 = 24'h004A13;
        ifa.req1 = 1'b1; ifa.addr1 = 24'h004A1C;
        tick();
        chk("t3.rd",    32'(ifa.fr_rd),   32'h1);
        chk("t3.addr",  32'(ifa.fr_addr), 32'h004A10);
        chk("t3.owner", 32'(ifa.owner),   32'h0);
        tick();
        ifa.fr_done = 1'b1;
        tick();
        ifa.fr_done = 1'b0;
        chk("t3.done0", 32'(ifa.done0), 32'h1);
        chk("t3.done1", 32'(ifa.done1), 32'h1);
        ifa.req0 = 1'b0; ifa.req1 = 1'b0;
        tick();
        tick();
        chk("t3.idle", 32'(ifa.busy), 32'h0);
        tick();
        chk("t3.no_rd", 32'(ifa.fr_rd), 32'h0);

        // Requester 1 drops after grant: still completes, no second read
        do_reset();
        ifa.req1 = 1'b1; ifa.addr1 = 24'h000777;
        tick();
        chk("t4.rd",    32'(ifa.fr_rd),   32'h1);
        chk("t4.owner", 32'(ifa.owner),   32'h1);
        chk("t4.addr",  32'(ifa.fr_addr), 32'h000770);
        ifa.req1 = 1'b0;
        tick();
        ifa.fr_done = 1'b1;
        tick();
        ifa.fr_done = 1'b0;
        chk("t4.done1", 32'(ifa.done1), 32'h1);
        chk("t4.done0", 32'(ifa.done0), 32'h0);
        tick();
        tick();
        chk("t4.idle", 32'(ifa.busy), 32'h0);
        tick();
        chk("t4.no_rd", 32'(ifa.fr_rd), 32'h0);
        chk("t4.still_idle", 32'(ifa.busy), 32'h0);

        // Asynchronous reset during BUSY, then spurious fr_done in IDLE
        do_reset();
        ifa.req1 = 1'b1; ifa.addr1 = 24'h00ABCD;
        tick();
        tick();
        chk("t5.busy_pre", 32'(ifa.busy),    32'h1);
        chk("t5.addr_pre", 32'(ifa.fr_addr), 32'h00ABC0);
        HRESETn = 1'b0;
        #1;
        chk_idle_a("t5.async");
        tick();
        HRESETn = 1'b1;
        ifa.req1 = 1'b0;
        tick();
        ifa.fr_done = 1'b1;
        tick();
        ifa.fr_done = 1'b0;
        tick();
        chk("t5.sp_done0", 32'(ifa.done0), 32'h0);
        chk("t5.sp_done1", 32'(ifa.done1), 32'h0);
        chk("t5.sp_busy",  32'(ifa.busy),  32'h0);
        ifa.req0 = 1'b1; ifa.addr0 = 24'h000045;
        tick();
        chk("t5.rd",    32'(ifa.fr_rd),   32'h1);
        chk("t5.addr",  32'(ifa.fr_addr), 32'h000040);
        chk("t5.owner", 32'(ifa.owner),   32'h0);

        // GAP_CYCLES = 0: continuous requests alternate back to back
        do_reset();
        ifb.req0 = 1'b1; ifb.addr0 = 24'h001000;
        ifb.req1 = 1'b1; ifb.addr1 = 24'h002000;
        tick();
        chk("t6.rd_a",    32'(ifb.fr_rd),   32'h1);
        chk("t6.owner_a", 32'(ifb.owner),   32'h0);
        chk("t6.addr_a",  32'(ifb.fr_addr), 32'h001000);
        tick();
        ifb.fr_done = 1'b1;
        tick();
        ifb.fr_done = 1'b0;
        chk("t6.done0_a", 32'(ifb.done0), 32'h1);
        chk("t6.idle_a",  32'(ifb.busy),  32'h0);
        chk("t6.rd_gap_a", 32'(ifb.fr_rd), 32'h0);
        tick();
        chk("t6.rd_b",    32'(ifb.fr_rd),   32'h1);
        chk("t6.owner_b", 32'(ifb.owner),   32'h1);
        chk("t6.addr_b",  32'(ifb.fr_addr), 32'h002000);
        tick();
        ifb.fr_done = 1'b1;
        tick();
        ifb.fr_done = 1'b0;
        chk("t6.done1_b", 32'(ifb.done1), 32'h1);
        chk("t6.done0_b", 32'(ifb.done0), 32'h0);
        tick();
        chk("t6.rd_c",    32'(ifb.fr_rd), 32'h1);
        chk("t6.owner_c", 32'(ifb.owner), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
